mem_loader_responder: RTL and testbench
=======================================

Name: mem_loader_responder

Overview:
- Memory-side responder for the single-cycle `cpu` core.
- Answers the core's instruction fetch (`instrAddr` -> `instr`) and data access (`dataAddr`/`writeData`/`we` -> `readData`) from two internal word RAMs.
- After reset it holds the core in reset and loads a program into instruction RAM from a byte-stream valid/ready port. Once loading completes it releases the core.
- Sits between the testbench/top-level and `cpu`. It drives the core's `n_reset`.

Parameters:
- IMEM_WORDS, 256, number of 32-bit words in instruction RAM (power of 2).
- DMEM_WORDS, 256, number of 32-bit words in data RAM (power of 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte; little-endian within each word.
- ld_last  in  1  qualifies the final byte of the program (sampled with ld_valid).
- ld_ready  out  1  loader may transfer a byte this cycle.
- cpu_n_reset  out  1  registered reset to the core; 0 while loading.
- ld_done  out  1  high in RUN state.
- addr_err  out  1  one-cycle registered pulse on any out-of-range access or loader overflow.
- instrAddr  in  32  core fetch byte address.
- instr  out  32  fetched instruction, combinational.
- dataAddr  in  32  core data byte address.
- writeData  in  32  core store data.
- we  in  1  core store enable.
- readData  out  32  load data, combinational.

Behaviour:
- Reset (async, n_reset=0):
  - state=LOAD; byte counter=0; word pointer=0; assembly register=0.
  - cpu_n_reset=0, addr_err=0, ld_done=0.
  - RAM contents are not cleared.
- Address mapping:
  - word index = addr[log2(N)+1:2]; addr[1:0] is ignored.
  - An address is out of range if any bit above log2(N)+1 is set.
- Fetch:
  - instr = imem[index], combinational, in every state.
  - Out-of-range fetch returns NOP = 32'h0000_0033 (add $0,$0,$0) and sets addr_err next cycle (RUN only).
- Data read:
  - readData = dmem[index], combinational, zero latency (the single-cycle core needs this).
  - Out of range returns 0.
- Data write:
  - dmem[index] <= writeData on the clock edge when we=1 and state=RUN.
  - Out-of-range write is dropped and pulses addr_err.
  - we in any other state is ignored.
- FSM: LOAD, FLUSH, RELEASE, RUN.
  - LOAD:
    - ld_ready=1. A transfer occurs when ld_valid & ld_ready.
    - Each transfer places ld_byte at bits [8*cnt+7:8*cnt] of the assembly register, then cnt++.
    - When cnt hits 3 on a transfer, the completed word is written to imem[ptr] that same edge; ptr++; cnt=0.
    - If ld_last arrives with that 4th byte: go to RELEASE.
    - If ld_last arrives with cnt<3: go to FLUSH.
  - FLUSH:
    - ld_ready=0.
    - Write the partial word, upper bytes zero-padded, to imem[ptr].
    - Go to RELEASE.
  - RELEASE:
    - ld_ready=0; cpu_n_reset stays 0 for this cycle, guaranteeing at least one reset cycle after the last write.
    - Go to RUN.
  - RUN:
    - cpu_n_reset=1 from the first RUN cycle (registered). ld_done=1. ld_ready=0. Loader inputs are ignored.
    - Exit only via n_reset.
- Overflow: when ptr==IMEM_WORDS, further bytes are still accepted (no stall) but discarded. addr_err pulses once per dropped word.
- ld_last with ld_valid=0 is ignored.
- Reset mid-load restarts from word 0; previously written words are stale but get overwritten by the new load.
- addr_err is registered: high for exactly the cycle after the offending event. Simultaneous events still produce a single pulse.

Decomposition:
- Package r4_mem_pkg:
  - enum ld_state_t {LOAD, FLUSH, RELEASE, RUN}.
  - localparam NOP_INSTR = 32'h0000_0033.
  - a function for word-index extraction and range check.
- Sub-module word_ram (parameter WORDS): one synchronous write port, one combinational read port. Instantiated twice (imem, dmem).
- FSM, byte packer and range checks live in the top.

Test Plan:
- Reset, then stream 8 bytes 13 00 10 00 | 33 81 10 00 with ld_last on byte 8 -> RELEASE then RUN. cpu_n_reset rises exactly 2 cycles after the last transfer. instrAddr=0 gives 32'h0010_0013; instrAddr=4 gives 32'h0010_8133.
- Stream 5 bytes AA BB CC DD EE with ld_last on byte 5 -> passes through FLUSH. imem[0]=32'hDDCC_BBAA, imem[1]=32'h0000_00EE, ld_done=1.
- In RUN: we=1, dataAddr=0, writeData=32'h01FE -> next cycle readData=32'h01FE. Same write with we=1 before RUN -> dmem unchanged.
- instrAddr=32'h0000_0400 with IMEM_WORDS=256 -> instr=32'h0000_0033 and addr_err high for one cycle. A store to dataAddr=32'h0000_0400 -> dmem unchanged, addr_err pulse.
- Assert n_reset=0 mid-word (after 2 bytes) -> cpu_n_reset=0 and ld_ready=1 immediately after release of reset. A reload of 4 bytes lands at imem[0].
- Feed IMEM_WORDS*4+4 bytes -> last 4 bytes are dropped, imem[0] is not overwritten, exactly one addr_err pulse.

Source files
------------

// File: rtl/r4_mem_pkg.sv
// Shared types and helpers for the memory-side responder.
// Loader FSM states, the fetch filler instruction and the address range check.
package r4_mem_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        FLUSH   = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } ld_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    // A byte address is in range when nothing above the word-index field is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned idx_bits);
        return (addr >> (idx_bits + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/word_ram.sv
// 32-bit word RAM: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge, read is zero-cycle. No backpressure.
// Contents are deliberately not reset.
module word_ram #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_loader_responder.sv
// Instruction/data memory for the single-cycle core, plus a byte-stream program loader.
// Latency: fetch and load are combinational; stores and loader writes land on the clock edge.
// Backpressure: ld_ready is high only in LOAD; bytes beyond instruction RAM are accepted and dropped.
module mem_loader_responder
    import r4_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_n_reset,
    output logic        ld_done,
    output logic        addr_err,
    input  logic [31:0] instrAddr,
    output logic [31:0] instr,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData
);

    localparam int unsigned IW = $clog2(IMEM_WORDS);
    localparam int unsigned DW = $clog2(DMEM_WORDS);

    ld_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [IW:0] ptr_q, ptr_d;
    logic [31:0] asm_q, asm_d;
    logic        cpu_n_reset_q, cpu_n_reset_d;
    logic        addr_err_q, addr_err_d;

    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_rdata;
    logic [31:0] packed_word;
    logic        loader_drop;
    logic        instr_ok;
    logic        data_ok;
    logic        dmem_we;

    assign instr_ok = addr_in_range(instrAddr, IW);
    assign data_ok  = addr_in_range(dataAddr, DW);
    assign dmem_we  = we && data_ok && (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        asm_d       = asm_q;
        ld_ready    = 1'b0;
        imem_we     = 1'b0;
        imem_wdata  = asm_q;
        loader_drop = 1'b0;
        packed_word = asm_q | ({24'b0, ld_byte} << {cnt_q, 3'b000});

        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (cnt_q == 2'd3) begin
                        imem_wdata = packed_word;
                        // ptr_q[IW] set means instruction RAM is full
                        if (!ptr_q[IW]) begin
                            imem_we = 1'b1;
                            ptr_d   = ptr_q + {{IW{1'b0}}, 1'b1};
                        end else begin
                            loader_drop = 1'b1;
                        end
                        cnt_d = 2'd0;
                        asm_d = 32'd0;
                        if (ld_last) state_d = RELEASE;
                    end else begin
                        asm_d = packed_word;
                        cnt_d = cnt_q + 2'd1;
                        if (ld_last) state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!ptr_q[IW]) begin
                    imem_we = 1'b1;
                    ptr_d   = ptr_q + {{IW{1'b0}}, 1'b1};
                end else begin
                    loader_drop = 1'b1;
                end
                cnt_d   = 2'd0;
                asm_d   = 32'd0;
                state_d = RELEASE;
            end
            RELEASE: state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase

        cpu_n_reset_d = (state_d == RUN);
        addr_err_d    = loader_drop ||
                        ((state_q == RUN) && (!instr_ok || (we && !data_ok)));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= LOAD;
            cnt_q         <= 2'd0;
            ptr_q         <= '0;
            asm_q         <= 32'd0;
            cpu_n_reset_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            asm_q         <= asm_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            addr_err_q    <= addr_err_d;
        end
    end

    word_ram #(.WORDS(IMEM_WORDS)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (ptr_q[IW-1:0]),
        .wdata (imem_wdata),
        .raddr (instrAddr[IW+1:2]),
        .rdata (imem_rdata)
    );

    word_ram #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (dataAddr[DW+1:2]),
        .wdata (writeData),
        .raddr (dataAddr[DW+1:2]),
        .rdata (dmem_rdata)
    );

    assign instr       = instr_ok ? imem_rdata : NOP_INSTR;
    assign readData    = data_ok ? dmem_rdata : 32'd0;
    assign cpu_n_reset = cpu_n_reset_q;
    assign addr_err    = addr_err_q;
    assign ld_done     = (state_q == RUN);

endmodule

// File: tb/tb_mem_loader_responder.sv
// Scoreboard bench for mem_loader_responder: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_loader_responder;

    localparam int SEL_INSTR = 0, SEL_RDATA = 1, SEL_CRST = 2, SEL_DONE = 3,
                   SEL_RDY = 4, SEL_ERR = 5, SEL_ERRCNT = 6;

    logic        clk;
    logic        n_reset;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_n_reset;
    logic        ld_done;
    logic        addr_err;
    logic [31:0] instrAddr;
    logic [31:0] instr;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic        we;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic cnt_clr = 1'b0;

    string       q_name[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];

    mem_loader_responder #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .cpu_n_reset (cpu_n_reset),
        .ld_done     (ld_done),
        .addr_err    (addr_err),
        .instrAddr   (instrAddr),
        .instr       (instr),
        .dataAddr    (dataAddr),
        .writeData   (writeData),
        .we          (we),
        .readData    (readData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (cnt_clr) err_cnt <= 0;
        else if (addr_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    // Monitor: compares every queued expectation at the negedge after it was issued.
    always @(negedge clk) begin
        string       n;
        int          s;
        logic [31:0] e;
        logic [31:0] act;
        while (q_sel.size() > 0) begin
            n = q_name.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            case (s)
                SEL_INSTR:  act = instr;
                SEL_RDATA:  act = readData;
                SEL_CRST:   act = {31'd0, cpu_n_reset};
                SEL_DONE:   act = {31'd0, ld_done};
                SEL_RDY:    act = {31'd0, ld_ready};
                SEL_ERR:    act = {31'd0, addr_err};
                default:    act = err_cnt;
            endcase
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        q_name.push_back(name);
        q_sel.push_back(sel);
        q_exp.push_back(val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    function automatic logic [7:0] ovf_byte(input int i);
        int v;
        v = i ^ (i >> 8);
        return v[7:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prog1 [8];
        prog1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00};

        n_reset = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        instrAddr = 32'd0; dataAddr = 32'd0; writeData = 32'd0; we = 1'b0;
        #1;

        // Reset state
        expect_val("rst_cpu_n_reset", SEL_CRST, 32'd0);
        expect_val("rst_ld_done", SEL_DONE, 32'd0);
        expect_val("rst_ld_ready", SEL_RDY, 32'd1);
        expect_val("rst_addr_err", SEL_ERR, 32'd0);
        tick();
        n_reset = 1'b1;

        // Two full words, ld_last on the 8th byte
        for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
        expect_val("release_cpu_n_reset", SEL_CRST, 32'd0);
        expect_val("release_ld_ready", SEL_RDY, 32'd0);
        tick();
        expect_val("run_cpu_n_reset", SEL_CRST, 32'd1);
        expect_val("run_ld_done", SEL_DONE, 32'd1);
        expect_val("imem0", SEL_INSTR, 32'h0010_0013);
        tick();
        instrAddr = 32'd4;
        expect_val("imem1", SEL_INSTR, 32'h0010_8133);
        we = 1'b1; dataAddr = 32'd0; writeData = 32'h0000_1234;
        tick();
        we = 1'b0;
        expect_val("store_run", SEL_RDATA, 32'h0000_1234);
        tick();

        // Out-of-range fetch
        instrAddr = 32'h0000_0400;
        expect_val("oor_fetch_nop", SEL_INSTR, 32'h0000_0033);
        tick();
        instrAddr = 32'd0;
        expect_val("oor_fetch_err", SEL_ERR, 32'd1);
        tick();
        expect_val("oor_fetch_err_clear", SEL_ERR, 32'd0);

        // Out-of-range store
        we = 1'b1; dataAddr = 32'h0000_0400; writeData = 32'hDEAD_BEEF;
        expect_val("oor_read_zero", SEL_RDATA, 32'd0);
        tick();
        we = 1'b0; dataAddr = 32'd0;
        expect_val("oor_store_err", SEL_ERR, 32'd1);
        expect_val("oor_store_dmem", SEL_RDATA, 32'h0000_1234);
        tick();
        expect_val("oor_store_err_clear", SEL_ERR, 32'd0);
        tick();

        // Partial final word through FLUSH; stores during load are ignored
        pulse_reset();
        we = 1'b1; dataAddr = 32'd0; writeData = 32'h0000_01FE;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        we = 1'b0;
        expect_val("flush_cpu_n_reset", SEL_CRST, 32'd0);
        expect_val("flush_ld_ready", SEL_RDY, 32'd0);
        tick();
        expect_val("flush_release_cpu_n_reset", SEL_CRST, 32'd0);
        tick();
        expect_val("flush_run_ld_done", SEL_DONE, 32'd1);
        expect_val("flush_run_cpu_n_reset", SEL_CRST, 32'd1);
        expect_val("store_before_run_ignored", SEL_RDATA, 32'h0000_1234);
        instrAddr = 32'd0;
        expect_val("flush_imem0", SEL_INSTR, 32'hDDCC_BBAA);
        tick();
        instrAddr = 32'd4;
        expect_val("flush_imem1", SEL_INSTR, 32'h0000_00EE);
        we = 1'b1; writeData = 32'h0000_01FE;
        tick();
        we = 1'b0;
        expect_val("store_01fe", SEL_RDATA, 32'h0000_01FE);
        tick();

        // Reset mid-word, then reload one word at imem[0]
        instrAddr = 32'd0;
        pulse_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        expect_val("midrst_cpu_n_reset", SEL_CRST, 32'd0);
        expect_val("midrst_ld_ready", SEL_RDY, 32'd1);
        expect_val("midrst_ld_done", SEL_DONE, 32'd0);
        tick();
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b1);
        tick();
        expect_val("reload_imem0", SEL_INSTR, 32'h1122_3344);
        tick();

        // Overflow: 1028 bytes into a 256-word RAM
        pulse_reset();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 1028; i++) send_byte(ovf_byte(i), i == 1027);
        tick();
        tick();
        instrAddr = 32'd0;
        expect_val("ovf_ld_done", SEL_DONE, 32'd1);
        expect_val("ovf_imem0", SEL_INSTR, 32'h0302_0100);
        tick();
        instrAddr = 32'h0000_03FC;
        expect_val("ovf_imem255", SEL_INSTR, 32'hFCFD_FEFF);
        tick();
        expect_val("ovf_err_pulses", SEL_ERRCNT, 32'd1);
        tick();
        tick();

        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
